// File: rtl/triangle_raster_scan_if.sv
// Triangle-in / pixel-out handshake bundle for triangle_raster_scan.
// The master side is the triangle source plus the pixel sink; the slave side is the scan engine.
interface triangle_raster_scan_if #(
   parameter int COORD_W = 12,
   parameter int CW_X    = 6,
   parameter int CW_Y    = 6
);
   logic               tri_valid;
   logic               tri_ready;
   logic [COORD_W-1:0] p1x, p1y, p2x, p2y, p3x, p3y;
   logic               pix_valid;
   logic               pix_ready;
   logic [CW_X-1:0]    pix_x;
   logic [CW_Y-1:0]    pix_y;
   logic               pix_inside;
   logic               pix_last;
   logic               busy;
   logic               done;
   logic               degenerate;

   modport master (
      output tri_valid, p1x, p1y, p2x, p2y, p3x, p3y, pix_ready,
      input  tri_ready, pix_valid, pix_x, pix_y, pix_inside, pix_last, busy, done, degenerate
   );

   modport slave (
      input  tri_valid, p1x, p1y, p2x, p2y, p3x, p3y, pix_ready,
      output tri_ready, pix_valid, pix_x, pix_y, pix_inside, pix_last, busy, done, degenerate
   );
endinterface

// File: rtl/triangle_raster_scan.sv
// Walks a WIDTH x HEIGHT raster (full frame or clipped bounding box) for one triangle at a time,
// streaming (x, y, inside, last) with backpressure.
module triangle_raster_scan #(
   parameter int COORD_W   = 12,
   parameter int WIDTH     = 41,
   parameter int HEIGHT    = 51,
   parameter int SCAN_MODE = 0,
   parameter int EDGE_MODE = 0
) (
   input logic clk,
   input logic rst_n,
   triangle_raster_scan_if.slave bus
);
   localparam int CW_X = $clog2(WIDTH);
   localparam int CW_Y = $clog2(HEIGHT);
   localparam int DW   = COORD_W + 1;
   localparam int PW   = 2 * COORD_W + 2;
   localparam int EW   = 2 * COORD_W + 3;

   localparam logic [COORD_W-1:0] XLIM   = COORD_W'(WIDTH - 1);
   localparam logic [COORD_W-1:0] YLIM   = COORD_W'(HEIGHT - 1);
   localparam logic [CW_X-1:0]    XMAX_R = CW_X'(WIDTH - 1);
   localparam logic [CW_Y-1:0]    YMAX_R = CW_Y'(HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

   state_t             state;
   logic [COORD_W-1:0] v1x, v1y, v2x, v2y, v3x, v3y;
   logic [CW_X-1:0]    xmin, xmax;
   logic [CW_Y-1:0]    ymin;
   logic               tri_ready, busy, done, degenerate;
   logic               pix_valid, pix_inside, pix_last;
   logic [CW_X-1:0]    pix_x;
   logic [CW_Y-1:0]    pix_y;

   function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
      logic [COORD_W-1:0] m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
      logic [COORD_W-1:0] m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Widths chosen so the full unsigned coordinate range can never overflow.
   function automatic logic signed [EW-1:0] edge_fn(input logic [COORD_W-1:0] ax, ay, bx, by, tx, ty);
      logic signed [DW-1:0] dtx, dty, dax, day;
      logic signed [PW-1:0] p0, p1;
      dtx = $signed({1'b0, tx}) - $signed({1'b0, bx});
      dty = $signed({1'b0, ty}) - $signed({1'b0, by});
      dax = $signed({1'b0, ax}) - $signed({1'b0, bx});
      day = $signed({1'b0, ay}) - $signed({1'b0, by});
      p0  = PW'(dtx) * PW'(day);
      p1  = PW'(dax) * PW'(dty);
      return EW'(p0) - EW'(p1);
   endfunction

   // Bounding box of the captured vertices, valid while in SETUP.
   logic [COORD_W-1:0] bx_lo, bx_hi, by_lo, by_hi;
   logic [CW_X-1:0]    sx_lo, sx_hi;
   logic [CW_Y-1:0]    sy_lo, sy_hi;
   logic               box_empty;

   always_comb begin
      bx_lo = min3(v1x, v2x, v3x);
      bx_hi = max3(v1x, v2x, v3x);
      by_lo = min3(v1y, v2y, v3y);
      by_hi = max3(v1y, v2y, v3y);
      if (SCAN_MODE == 0) begin
         sx_lo     = '0;
         sx_hi     = XMAX_R;
         sy_lo     = '0;
         sy_hi     = YMAX_R;
         box_empty = 1'b0;
      end else begin
         box_empty = (bx_lo > XLIM) || (by_lo > YLIM);
         sx_lo     = CW_X'(bx_lo);
         sy_lo     = CW_Y'(by_lo);
         sx_hi     = (bx_hi > XLIM) ? XMAX_R : CW_X'(bx_hi);
         sy_hi     = (by_hi > YLIM) ? YMAX_R : CW_Y'(by_hi);
      end
   end

   // Next pixel to present: box corner in SETUP, otherwise one step along the row-major walk.
   logic [CW_X-1:0] nx, lx;
   logic [CW_Y-1:0] ny, ly;
   logic            n_last;

   always_comb begin
      nx = pix_x;
      ny = pix_y;
      lx = xmax;
      ly = ymin;
      if (state == SETUP) begin
         nx = sx_lo;
         ny = sy_hi;
         lx = sx_hi;
         ly = sy_lo;
      end else if (pix_x == xmax) begin
         nx = xmin;
         ny = pix_y - CW_Y'(1);
      end else begin
         nx = pix_x + CW_X'(1);
      end
      n_last = (nx == lx) && (ny == ly);
   end

   logic signed [EW-1:0] e0, e1, e2, deg_e;
   logic [2:0]           ge, le, gt, lt;
   logic                 n_inside;

   always_comb begin
      e0    = edge_fn(v1x, v1y, v2x, v2y, COORD_W'(nx), COORD_W'(ny));
      e1    = edge_fn(v2x, v2y, v3x, v3y, COORD_W'(nx), COORD_W'(ny));
      e2    = edge_fn(v3x, v3y, v1x, v1y, COORD_W'(nx), COORD_W'(ny));
      deg_e = edge_fn(v1x, v1y, v2x, v2y, v3x, v3y);
      lt    = {e2[EW-1], e1[EW-1], e0[EW-1]};
      ge    = ~lt;
      le    = lt | {e2 == '0, e1 == '0, e0 == '0};
      gt    = ~le;
      case (EDGE_MODE)
         0:       n_inside = (ge == 3'b111) || (ge == 3'b000);
         1:       n_inside = (&ge) || (&le);
         default: n_inside = (&gt) || (&lt);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         {v1x, v1y, v2x, v2y, v3x, v3y} <= '0;
         xmin       <= '0;
         xmax       <= '0;
         ymin       <= '0;
         tri_ready  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         degenerate <= 1'b0;
         pix_valid  <= 1'b0;
         pix_x      <= '0;
         pix_y      <= '0;
         pix_inside <= 1'b0;
         pix_last   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.tri_valid && tri_ready) begin
                  {v1x, v1y} <= {bus.p1x, bus.p1y};
                  {v2x, v2y} <= {bus.p2x, bus.p2y};
                  {v3x, v3y} <= {bus.p3x, bus.p3y};
                  tri_ready  <= 1'b0;
                  busy       <= 1'b1;
                  state      <= SETUP;
               end else begin
                  tri_ready  <= 1'b1;
               end
            end
            SETUP: begin
               xmin       <= sx_lo;
               xmax       <= sx_hi;
               ymin       <= sy_lo;
               degenerate <= (deg_e == '0);
               if (box_empty) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  pix_valid  <= 1'b1;
                  pix_x      <= nx;
                  pix_y      <= ny;
                  pix_inside <= n_inside;
                  pix_last   <= n_last;
                  state      <= SCAN;
               end
            end
            SCAN: begin
               if (bus.pix_ready) begin
                  if (pix_last) begin
                     pix_valid <= 1'b0;
                     pix_last  <= 1'b0;
                     done      <= 1'b1;
                     state     <= DONE;
                  end else begin
                     pix_x      <= nx;
                     pix_y      <= ny;
                     pix_inside <= n_inside;
                     pix_last   <= n_last;
                  end
               end
            end
            default: begin
               busy      <= 1'b0;
               tri_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.tri_ready  = tri_ready;
   assign bus.pix_valid  = pix_valid;
   assign bus.pix_x      = pix_x;
   assign bus.pix_y      = pix_y;
   assign bus.pix_inside = pix_inside;
   assign bus.pix_last   = pix_last;
   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.degenerate = degenerate;
endmodule

// File: tb/tb_triangle_raster_scan.sv
// Bench: three scan engines (full/legacy, box/inclusive, box/strict) share one stimulus stream
// and are checked against a per-pixel edge-function reference model.
module tb_triangle_raster_scan;
   localparam int CW   = 12;
   localparam int W    = 41;
   localparam int H    = 51;
   localparam int CX   = $clog2(W);
   localparam int CY   = $clog2(H);
   localparam int MAXP = 2100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tri_valid = 1'b0;
   logic          pix_ready = 1'b1;
   logic [CW-1:0] vx [3];
   logic [CW-1:0] vy [3];

   wire [2:0]    pv, tr, pl, pin, bsy, dn, dg;
   wire [CX-1:0] px [3];
   wire [CY-1:0] py [3];

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g
      triangle_raster_scan_if #(.COORD_W(CW), .CW_X(CX), .CW_Y(CY)) bus ();
      triangle_raster_scan #(
         .COORD_W(CW), .WIDTH(W), .HEIGHT(H),
         .SCAN_MODE((k == 0) ? 0 : 1), .EDGE_MODE(k)
      ) dut (
         .clk(clk), .rst_n(rst_n), .bus(bus)
      );
      assign bus.tri_valid = tri_valid;
      assign bus.p1x = vx[0];
      assign bus.p1y = vy[0];
      assign bus.p2x = vx[1];
      assign bus.p2y = vy[1];
      assign bus.p3x = vx[2];
      assign bus.p3y = vy[2];
      assign bus.pix_ready = pix_ready;
      assign pv[k]  = bus.pix_valid;
      assign tr[k]  = bus.tri_ready;
      assign pl[k]  = bus.pix_last;
      assign pin[k] = bus.pix_inside;
      assign bsy[k] = bus.busy;
      assign dn[k]  = bus.done;
      assign dg[k]  = bus.degenerate;
      assign px[k]  = bus.pix_x;
      assign py[k]  = bus.pix_y;
   end

   int tests = 0, fails = 0, cyc = 0;
   bit mon_en = 1'b0;
   int got [3][MAXP];
   int exp_pix [3][MAXP];
   int gcnt [3], ecnt [3];
   int hs_cyc [3], first_pv [3], last_acc [3], done_cyc [3], done_cnt [3], stall_err [3];
   int tv [6];

   function automatic int pk(input int x, input int y, input int ins, input int last);
      return x | (y << 8) | (ins << 16) | (last << 17);
   endfunction

   function automatic longint ef(input longint ax, ay, bx, by, tx, ty);
      return (tx - bx) * (ay - by) - (ax - bx) * (ty - by);
   endfunction

   function automatic int ins_rule(input int m, input longint e0, e1, e2);
      if (m == 0) return int'(((e0 >= 0) == (e1 >= 0)) && ((e1 >= 0) == (e2 >= 0)));
      if (m == 1) return int'((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0));
      return int'((e0 > 0 && e1 > 0 && e2 > 0) || (e0 < 0 && e1 < 0 && e2 < 0));
   endfunction

   function automatic int mn3(input int a, b, c);
      int m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   function automatic int mx3(input int a, b, c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Expected stream for engine k: rows ymax..ymin, columns xmin..xmax.
   task automatic build_exp(input int k);
      int xl, xh, yl, yh;
      bit empty;
      longint e0, e1, e2;
      if (k == 0) begin
         xl = 0; xh = W - 1; yl = 0; yh = H - 1; empty = 1'b0;
      end else begin
         xl = mn3(tv[0], tv[2], tv[4]);
         xh = mx3(tv[0], tv[2], tv[4]);
         yl = mn3(tv[1], tv[3], tv[5]);
         yh = mx3(tv[1], tv[3], tv[5]);
         empty = (xl > W - 1) || (yl > H - 1);
         if (xh > W - 1) xh = W - 1;
         if (yh > H - 1) yh = H - 1;
      end
      ecnt[k] = 0;
      if (!empty)
         for (int y = yh; y >= yl; y--)
            for (int x = xl; x <= xh; x++) begin
               e0 = ef(tv[0], tv[1], tv[2], tv[3], x, y);
               e1 = ef(tv[2], tv[3], tv[4], tv[5], x, y);
               e2 = ef(tv[4], tv[5], tv[0], tv[1], x, y);
               exp_pix[k][ecnt[k]] = pk(x, y, ins_rule(k, e0, e1, e2), int'(x == xh && y == yl));
               ecnt[k]++;
            end
   endtask

   function automatic int seq_diff(input int k);
      int d = 0;
      if (gcnt[k] != ecnt[k]) return 1000000 + gcnt[k];
      for (int i = 0; i < ecnt[k]; i++)
         if (got[k][i] != exp_pix[k][i]) d++;
      return d;
   endfunction

   // Bit flags: 1 stall instability, 2 done count, 4 first-pixel latency, 8 done latency, 16 empty-box timing.
   function automatic int proto_err(input int k);
      int r = 0;
      if (stall_err[k] != 0) r |= 1;
      if (done_cnt[k] != 1) r |= 2;
      if (ecnt[k] > 0) begin
         if (first_pv[k] != hs_cyc[k] + 2) r |= 4;
         if (done_cyc[k] != last_acc[k] + 1) r |= 8;
      end else if (done_cyc[k] != hs_cyc[k] + 2 || first_pv[k] != -1) r |= 16;
      return r;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   initial begin : mon
      logic [2:0]    pv_q;
      logic          rdy_q;
      logic [CX-1:0] px_q [3];
      logic [CY-1:0] py_q [3];
      logic [2:0]    pin_q, pl_q;
      pv_q = '0;
      rdy_q = 1'b1;
      forever begin
         @(negedge clk);
         if (mon_en)
            for (int k = 0; k < 3; k++) begin
               if (tri_valid && tr[k]) hs_cyc[k] = cyc;
               if (pv[k] && first_pv[k] < 0) first_pv[k] = cyc;
               if (pv_q[k] && !rdy_q && (!pv[k] || px[k] !== px_q[k] || py[k] !== py_q[k] ||
                   pin[k] !== pin_q[k] || pl[k] !== pl_q[k]))
                  stall_err[k]++;
               if (pv[k] && pix_ready) begin
                  if (gcnt[k] < MAXP) got[k][gcnt[k]] = pk(int'(px[k]), int'(py[k]), int'(pin[k]), int'(pl[k]));
                  gcnt[k]++;
                  last_acc[k] = cyc;
               end
               if (dn[k]) begin
                  done_cnt[k]++;
                  done_cyc[k] = cyc;
               end
            end
         pv_q  = mon_en ? pv : 3'b000;
         rdy_q = pix_ready;
         px_q  = px;
         py_q  = py;
         pin_q = pin;
         pl_q  = pl;
      end
   end

   task automatic run_tri(input int x1, y1, x2, y2, x3, y3, input bit rnd, input int stop_at);
      int n;
      tv = '{x1, y1, x2, y2, x3, y3};
      for (int k = 0; k < 3; k++) begin
         gcnt[k] = 0; hs_cyc[k] = -1; first_pv[k] = -1; last_acc[k] = -1;
         done_cyc[k] = -1; done_cnt[k] = 0; stall_err[k] = 0;
         build_exp(k);
      end
      vx[0] = CW'(x1); vy[0] = CW'(y1);
      vx[1] = CW'(x2); vy[1] = CW'(y2);
      vx[2] = CW'(x3); vy[2] = CW'(y3);
      tri_valid = 1'b1;
      pix_ready = 1'b1;
      mon_en = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (tr != 3'b000 && n < 20);
      tri_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vx[i] = CW'($urandom_range(0, 4095));
         vy[i] = CW'($urandom_range(0, 4095));
      end
      tests++;
      if (tr !== 3'b000) begin
         fails++;
         $display("FAIL handshake: tri_ready=%b required 000", tr);
      end
      n = 0;
      while (bsy != 3'b000 && n < 10000 && !(stop_at > 0 && gcnt[0] >= stop_at)) begin
         pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         n++;
      end
      if (stop_at == 0) begin
         tests++;
         if (bsy !== 3'b000) begin
            fails++;
            $display("FAIL scan_timeout: busy=%b after %0d cycles required 000", bsy, n);
         end
      end
      mon_en = 1'b0;
      pix_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      tests++;
      if ({pv, tr, bsy, dn, dg, pl, pin} !== '0) begin
         fails++;
         $display("FAIL reset_flags: pv=%b tr=%b busy=%b done=%b deg=%b last=%b ins=%b required all 0",
                  pv, tr, bsy, dn, dg, pl, pin);
      end
      for (int k = 0; k < 3; k++) begin
         tests++;
         if ({px[k], py[k]} !== '0) begin
            fails++;
            $display("FAIL reset_xy[%0d]: x=%0d y=%0d required 0 0", k, px[k], py[k]);
         end
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (tr !== 3'b111) begin
         fails++;
         $display("FAIL reset_release_ready: tri_ready=%b required 111", tr);
      end
   endtask

   task automatic test_full_frame();
      run_tri(10, 10, 10, 30, 30, 20, 1'b0, 0);
      tests++;
      if (gcnt[0] !== 2091) begin fails++; $display("FAIL full_count: got %0d required 2091", gcnt[0]); end
      tests++;
      if ((got[0][0] & 32'hffff) !== pk(0, 50, 0, 0)) begin
         fails++; $display("FAIL full_first: got %h required %h", got[0][0] & 32'hffff, pk(0, 50, 0, 0));
      end
      tests++;
      if ((got[0][2090] & 32'h2ffff) !== pk(40, 0, 0, 1)) begin
         fails++; $display("FAIL full_last: got %h required %h", got[0][2090] & 32'h2ffff, pk(40, 0, 0, 1));
      end
      tests++;
      if (((got[0][30 * 41 + 15] >> 16) & 1) !== 1) begin fails++; $display("FAIL full_in_15_20: got 0 required 1"); end
      tests++;
      if (((got[0][45 * 41 + 5] >> 16) & 1) !== 0) begin fails++; $display("FAIL full_in_5_5: got 1 required 0"); end
      tests++;
      if (dg !== 3'b000) begin fails++; $display("FAIL full_degenerate: got %b required 000", dg); end
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (seq_diff(k) !== 0) begin fails++; $display("FAIL full_seq[%0d]: diff %0d required 0", k, seq_diff(k)); end
         tests++;
         if (proto_err(k) !== 0) begin fails++; $display("FAIL full_proto[%0d]: flags %0d required 0", k, proto_err(k)); end
      end
   endtask

   task automatic test_bbox_edges();
      run_tri(10, 10, 10, 30, 30, 20, 1'b0, 0);
      tests++;
      if (gcnt[1] !== 441 || gcnt[2] !== 441) begin
         fails++; $display("FAIL box_count: got %0d/%0d required 441", gcnt[1], gcnt[2]);
      end
      tests++;
      if ((got[1][0] & 32'hffff) !== pk(10, 30, 0, 0)) begin
         fails++; $display("FAIL box_first: got %h required %h", got[1][0] & 32'hffff, pk(10, 30, 0, 0));
      end
      tests++;
      if ((got[1][440] & 32'h2ffff) !== pk(30, 10, 0, 1)) begin
         fails++; $display("FAIL box_last: got %h required %h", got[1][440] & 32'h2ffff, pk(30, 10, 0, 1));
      end
      tests++;
      if ({(got[0][30 * 41 + 10] >> 16) & 1, (got[1][210] >> 16) & 1, (got[2][210] >> 16) & 1} !== {32'd0, 32'd1, 32'd0}) begin
         fails++; $display("FAIL edge_pt_10_20: modes0/1/2 got %0d%0d%0d required 010",
                           (got[0][1240] >> 16) & 1, (got[1][210] >> 16) & 1, (got[2][210] >> 16) & 1);
      end
      tests++;
      if ((((got[1][215] >> 16) & 1) !== 1) || (((got[2][215] >> 16) & 1) !== 1)) begin
         fails++; $display("FAIL inner_pt_15_20: got %0d%0d required 11", (got[1][215] >> 16) & 1, (got[2][215] >> 16) & 1);
      end
      for (int k = 1; k < 3; k++) begin
         tests++;
         if (seq_diff(k) !== 0) begin fails++; $display("FAIL box_seq[%0d]: diff %0d required 0", k, seq_diff(k)); end
      end
   endtask

   task automatic test_backpressure();
      run_tri(10, 10, 10, 30, 30, 20, 1'b1, 0);
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (seq_diff(k) !== 0) begin fails++; $display("FAIL bp_seq[%0d]: diff %0d required 0", k, seq_diff(k)); end
         tests++;
         if (proto_err(k) !== 0) begin fails++; $display("FAIL bp_proto[%0d]: flags %0d required 0", k, proto_err(k)); end
      end
   endtask

   task automatic test_degenerate();
      run_tri(0, 0, 10, 10, 20, 20, 1'b0, 0);
      tests++;
      if (dg !== 3'b111) begin fails++; $display("FAIL degenerate_flag: got %b required 111", dg); end
      tests++;
      if ({(got[0][45 * 41 + 5] >> 16) & 1, (got[1][15 * 21 + 5] >> 16) & 1, (got[2][15 * 21 + 5] >> 16) & 1}
          !== {32'd1, 32'd1, 32'd0}) begin
         fails++; $display("FAIL degen_5_5: modes0/1/2 got %0d%0d%0d required 110", (got[0][1850] >> 16) & 1,
                           (got[1][320] >> 16) & 1, (got[2][320] >> 16) & 1);
      end
      tests++;
      if ({(got[0][44 * 41 + 5] >> 16) & 1, (got[1][14 * 21 + 5] >> 16) & 1, (got[2][14 * 21 + 5] >> 16) & 1}
          !== {32'd0, 32'd0, 32'd0}) begin
         fails++; $display("FAIL degen_5_6: modes0/1/2 got %0d%0d%0d required 000", (got[0][1809] >> 16) & 1,
                           (got[1][299] >> 16) & 1, (got[2][299] >> 16) & 1);
      end
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (seq_diff(k) !== 0) begin fails++; $display("FAIL degen_seq[%0d]: diff %0d required 0", k, seq_diff(k)); end
      end
   endtask

   task automatic test_empty_box();
      run_tri(100, 120, 200, 100, 150, 300, 1'b0, 0);
      tests++;
      if (gcnt[1] !== 0 || gcnt[2] !== 0) begin
         fails++; $display("FAIL empty_count: got %0d/%0d required 0", gcnt[1], gcnt[2]);
      end
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (proto_err(k) !== 0) begin fails++; $display("FAIL empty_proto[%0d]: flags %0d required 0", k, proto_err(k)); end
      end
      tests++;
      if (seq_diff(0) !== 0) begin fails++; $display("FAIL empty_full_seq: diff %0d required 0", seq_diff(0)); end
   endtask

   task automatic test_mid_reset();
      run_tri(10, 10, 10, 30, 30, 20, 1'b0, 100);
      tests++;
      if (gcnt[0] !== 100) begin fails++; $display("FAIL midrst_count: got %0d required 100", gcnt[0]); end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({pv, bsy} !== '0) begin fails++; $display("FAIL midrst_abort: pv=%b busy=%b required 000 000", pv, bsy); end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (tr !== 3'b111) begin fails++; $display("FAIL midrst_ready: tri_ready=%b required 111", tr); end
      run_tri(5, 40, 35, 45, 20, 2, 1'b0, 0);
      tests++;
      if ((got[1][0] & 32'hffff) !== pk(5, 45, 0, 0)) begin
         fails++; $display("FAIL midrst_first: got %h required %h", got[1][0] & 32'hffff, pk(5, 45, 0, 0));
      end
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (seq_diff(k) !== 0) begin fails++; $display("FAIL midrst_seq[%0d]: diff %0d required 0", k, seq_diff(k)); end
         tests++;
         if (proto_err(k) !== 0) begin fails++; $display("FAIL midrst_proto[%0d]: flags %0d required 0", k, proto_err(k)); end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         run_tri($urandom_range(0, 60), $urandom_range(0, 70), $urandom_range(0, 60),
                 $urandom_range(0, 70), $urandom_range(0, 60), $urandom_range(0, 70), 1'b1, 0);
         for (int k = 0; k < 3; k++) begin
            tests++;
            if (seq_diff(k) !== 0) begin
               fails++; $display("FAIL rand%0d_seq[%0d]: diff %0d required 0", it, k, seq_diff(k));
            end
            tests++;
            if (proto_err(k) !== 0) begin
               fails++; $display("FAIL rand%0d_proto[%0d]: flags %0d required 0", it, k, proto_err(k));
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         vx[i] = '0;
         vy[i] = '0;
      end
      test_reset();
      test_full_frame();
      test_bbox_edges();
      test_backpressure();
      test_degenerate();
      test_empty_box();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
